// File: rtl/t03_pc_fetch.sv
// Program counter and instruction fetch unit: fetches one instruction at a time
// over a req/ack port, holds it until retired, and redirects on taken branches.
module t03_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        retire,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]     PC_INIT  = {RESET_PC[31:2], 2'b00};

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misaligned_q, misaligned_d;
    logic             bus_error_q, bus_error_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        cnt_d        = cnt_q;
        misaligned_d = 1'b0;
        bus_error_d  = bus_error_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (fetch_ack) begin
                    instr_d = fetch_data;
                    cnt_d   = '0;
                    state_d = S_VALID;
                end else if (cnt_q == CNT_LAST) begin
                    bus_error_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VALID: begin
                if (retire) begin
                    pc_d         = branch_taken ? {branch_target[31:2], 2'b00} : pc_q + 32'd4;
                    misaligned_d = branch_taken && (branch_target[1:0] != 2'b00);
                    state_d      = enable ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_INIT;
            instr_q      <= '0;
            cnt_q        <= '0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            cnt_q        <= cnt_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign fetch_req   = (state_q == S_FETCH);
    assign fetch_addr  = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_VALID);
    assign misaligned  = misaligned_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_t03_pc_fetch.sv
// Self-checking bench for t03_pc_fetch: directed scenarios plus a randomized
// retire/branch/ack sequence checked against a transaction-level PC model.
module tb_t03_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        retire;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned;
    logic        bus_error;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: where the PC should be and what instr should hold.
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    t03_pc_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .retire(retire), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .pc(pc),
        .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
        .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        for (int i = 0; i < 40 && !fetch_req; i++) tick();
        ok = fetch_req;
    endtask

    // Answer the pending fetch after 'delay' idle cycles; reports the address seen.
    task automatic serve(input logic [31:0] data, input int delay,
                         output logic [31:0] addr, output bit ok);
        wait_req(ok);
        addr = fetch_addr;
        if (ok) begin
            for (int i = 0; i < delay; i++) begin
                fetch_data = $urandom;
                tick();
            end
            fetch_ack  = 1'b1;
            fetch_data = data;
            tick();
            fetch_ack  = 1'b0;
            fetch_data = $urandom;
        end
    endtask

    task automatic do_retire(input logic taken, input logic [31:0] target);
        branch_taken  = taken;
        branch_target = target;
        retire        = 1'b1;
        tick();
        retire        = 1'b0;
        branch_taken  = $urandom;
        branch_target = $urandom;
        exp_pc = taken ? (target & 32'hFFFF_FFFC) : exp_pc + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; branch_taken = 1'b0; branch_target = '0;
        retire = 1'b0; fetch_ack = 1'b0; fetch_data = '0;
        #2;
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if ({fetch_req, instr_valid, misaligned, bus_error} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {fetch_req, instr_valid, misaligned, bus_error});
        else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else n_pass++;
        tick(); tick();
        exp_pc = 32'h0;
    endtask

    task automatic test_first_fetch();
        rst = 1'b0; enable = 1'b1;
        tick();
        n_checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0)
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", fetch_req, fetch_addr);
        else n_pass++;
        fetch_ack = 1'b1; fetch_data = 32'h0000_0013;
        tick();
        fetch_ack = 1'b0; fetch_data = 32'hDEAD_BEEF;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h13 || fetch_req !== 1'b0)
            $display("FAIL first_instr: got v=%b instr=%h req=%b want v=1 instr=13 req=0", instr_valid, instr, fetch_req);
        else n_pass++;
        exp_instr = 32'h13;
    endtask

    task automatic test_sequential();
        logic [31:0] addr;
        logic [31:0] d;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            do_retire(1'b0, 32'h0);
            n_checks++; if (fetch_req !== 1'b1 || fetch_addr !== exp_pc || pc_plus4 !== exp_pc + 32'd4)
                $display("FAIL seq_addr: got req=%b addr=%h p4=%h want addr=%h", fetch_req, fetch_addr, pc_plus4, exp_pc);
            else n_pass++;
            d = $urandom;
            serve(d, $urandom_range(0, 3), addr, ok);
            n_checks++; if (!ok || instr !== d || instr_valid !== 1'b1)
                $display("FAIL seq_instr: got ok=%b v=%b instr=%h want %h", ok, instr_valid, instr, d);
            else n_pass++;
        end
        n_checks++; if (pc !== 32'h0000_000C) $display("FAIL seq_pc_c: got %h want 0000000c", pc); else n_pass++;
    endtask

    task automatic test_branch();
        logic [31:0] addr;
        bit ok;
        do_retire(1'b1, 32'h0000_0102);
        n_checks++; if (misaligned !== 1'b1 || pc !== 32'h100 || fetch_addr !== 32'h100)
            $display("FAIL branch_mis: got mis=%b pc=%h addr=%h want 1/100/100", misaligned, pc, fetch_addr);
        else n_pass++;
        tick();
        n_checks++; if (misaligned !== 1'b0 || fetch_req !== 1'b1)
            $display("FAIL branch_pulse: got mis=%b req=%b want mis=0 req=1", misaligned, fetch_req);
        else n_pass++;
        serve(32'hA5A5_0001, 0, addr, ok);
        exp_instr = 32'hA5A5_0001;
        n_checks++; if (!ok || addr !== 32'h100 || instr !== exp_instr)
            $display("FAIL branch_fetch: got addr=%h instr=%h want 100/%h", addr, instr, exp_instr);
        else n_pass++;
    endtask

    task automatic test_hold();
        branch_taken = 1'b1; branch_target = 32'h40;
        for (int k = 0; k < 3; k++) begin
            fetch_ack = k[0]; fetch_data = $urandom;
            tick();
            n_checks++; if (pc !== exp_pc || instr !== exp_instr || instr_valid !== 1'b1 || fetch_req !== 1'b0)
                $display("FAIL hold: got pc=%h instr=%h v=%b req=%b want pc=%h instr=%h", pc, instr, instr_valid, fetch_req, exp_pc, exp_instr);
            else n_pass++;
        end
        fetch_ack = 1'b0;
    endtask

    task automatic test_enable();
        logic [31:0] addr;
        bit ok;
        enable = 1'b0;
        do_retire(1'b0, 32'h0);
        tick();
        n_checks++; if (fetch_req !== 1'b0 || instr_valid !== 1'b0 || pc !== exp_pc)
            $display("FAIL enable_park: got req=%b v=%b pc=%h want 0/0/%h", fetch_req, instr_valid, pc, exp_pc);
        else n_pass++;
        enable = 1'b1;
        wait_req(ok);
        enable = 1'b0;
        serve(32'h1234_5678, 2, addr, ok);
        exp_instr = 32'h1234_5678;
        n_checks++; if (!ok || instr_valid !== 1'b1 || instr !== exp_instr || addr !== exp_pc)
            $display("FAIL enable_midfetch: got v=%b instr=%h addr=%h want 1/%h/%h", instr_valid, instr, addr, exp_instr, exp_pc);
        else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] tgt;
        logic        tk;
        logic        exp_mis;
        bit ok;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                branch_taken = $urandom; branch_target = $urandom;
                tick();
            end
            tk  = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
            exp_mis = tk && (tgt[1:0] != 2'b00);
            do_retire(tk, tgt);
            n_checks++; if (misaligned !== exp_mis || pc !== exp_pc || fetch_addr !== exp_pc)
                $display("FAIL rand_retire[%0d]: got mis=%b pc=%h want mis=%b pc=%h", k, misaligned, pc, exp_mis, exp_pc);
            else n_pass++;
            exp_instr = $urandom;
            serve(exp_instr, $urandom_range(0, 6), addr, ok);
            n_checks++; if (!ok || instr !== exp_instr || instr_valid !== 1'b1 || addr !== exp_pc)
                $display("FAIL rand_fetch[%0d]: got instr=%h addr=%h want %h/%h", k, instr, addr, exp_instr, exp_pc);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addr;
        bit ok;
        do_retire(1'b1, 32'hFFFF_FFFC);
        serve(32'h0000_0001, 0, addr, ok);
        n_checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0)
            $display("FAIL wrap_p4: got pc=%h p4=%h want fffffffc/0", pc, pc_plus4);
        else n_pass++;
        do_retire(1'b0, 32'h0);
        n_checks++; if (pc !== 32'h0 || fetch_addr !== 32'h0 || misaligned !== 1'b0)
            $display("FAIL wrap_pc: got pc=%h addr=%h mis=%b want 0/0/0", pc, fetch_addr, misaligned);
        else n_pass++;
        serve(32'h0000_0002, 1, addr, ok);
    endtask

    task automatic test_timeout();
        do_retire(1'b1, 32'h0000_0200);
        repeat (15) tick();
        n_checks++; if (fetch_req !== 1'b1 || bus_error !== 1'b0)
            $display("FAIL tmo_cycle16: got req=%b err=%b want 1/0", fetch_req, bus_error);
        else n_pass++;
        fetch_ack = 1'b1; fetch_data = 32'h0BAD_F00D;
        tick();
        fetch_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h0BAD_F00D || bus_error !== 1'b0)
            $display("FAIL tmo_late_ack: got v=%b instr=%h err=%b want 1/0badf00d/0", instr_valid, instr, bus_error);
        else n_pass++;
        do_retire(1'b0, 32'h0);
        repeat (15) tick();
        n_checks++; if (bus_error !== 1'b0 || fetch_req !== 1'b1)
            $display("FAIL tmo_pre: got err=%b req=%b want 0/1", bus_error, fetch_req);
        else n_pass++;
        tick();
        n_checks++; if (bus_error !== 1'b1 || fetch_req !== 1'b0 || instr_valid !== 1'b0 || pc !== exp_pc)
            $display("FAIL tmo_error: got err=%b req=%b v=%b pc=%h want 1/0/0/%h", bus_error, fetch_req, instr_valid, pc, exp_pc);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            fetch_ack = $urandom; retire = $urandom; branch_taken = $urandom;
            tick();
        end
        fetch_ack = 1'b0; retire = 1'b0;
        n_checks++; if (bus_error !== 1'b1 || fetch_req !== 1'b0 || instr_valid !== 1'b0 || pc !== exp_pc)
            $display("FAIL tmo_halt: got err=%b req=%b v=%b pc=%h want 1/0/0/%h", bus_error, fetch_req, instr_valid, pc, exp_pc);
        else n_pass++;
    endtask

    task automatic test_rst_mid_fetch();
        bit ok;
        rst = 1'b1; enable = 1'b1;
        #1;
        n_checks++; if (bus_error !== 1'b0 || pc !== 32'h0 || instr !== 32'h0)
            $display("FAIL rst_halt: got err=%b pc=%h instr=%h want 0/0/0", bus_error, pc, instr);
        else n_pass++;
        tick();
        rst = 1'b0;
        wait_req(ok);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (!ok || fetch_req !== 1'b0 || pc !== 32'h0)
            $display("FAIL rst_mid: got ok=%b req=%b pc=%h want 1/0/0", ok, fetch_req, pc);
        else n_pass++;
        tick();
        enable = 1'b0; rst = 1'b0;
        fetch_ack = 1'b1; fetch_data = 32'hCAFE_CAFE;
        tick(); tick();
        fetch_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || fetch_req !== 1'b0)
            $display("FAIL rst_late_ack: got v=%b instr=%h req=%b want 0/0/0", instr_valid, instr, fetch_req);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_hold();
        test_enable();
        test_random();
        test_wrap();
        test_timeout();
        test_rst_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
